// File: rtl/package_assembler_if.sv
// Byte-link bus of the package assembler: incoming byte stream plus the
// rebuilt record, its status pulses and a state debug tap.
//
// Handshake: data_valid high for one cycle means data_in carries one byte
// that is consumed at that rising edge; there is no ready/backpressure, the
// receiver always accepts. packet_valid and frame_error are one-cycle pulses.
interface package_assembler_if;
  logic [7:0]  data_in;
  logic        data_valid;
  logic [6:0]  child;
  logic [31:0] latitude;
  logic [31:0] longitude;
  logic        packet_valid;
  logic        frame_error;
  logic        busy;
  logic [1:0]  state_dbg;

  // Link side: drives bytes, observes the decoded record.
  modport master (
    output data_in, data_valid,
    input  child, latitude, longitude, packet_valid, frame_error, busy, state_dbg
  );

  // Assembler side.
  modport slave (
    input  data_in, data_valid,
    output child, latitude, longitude, packet_valid, frame_error, busy, state_dbg
  );
endinterface

// File: rtl/package_assembler.sv
// package_assembler: rebuilds the child/latitude/longitude record from the
// slicer byte stream. Header byte (bit7=1, child in [6:0]), then latitude and
// longitude, 4 bytes each, MSB first. Optional macro CHECKSUM_EN adds a 10th
// byte holding the XOR of the first nine; without it frames are 9 bytes.
// Stalled frames (TIMEOUT idle cycles inside a frame) are dropped with a
// frame_error pulse; outputs only change when a good frame is committed.
module package_assembler #(
  parameter logic [15:0] TIMEOUT = 16'd1000
) (
  input logic           clock,
  input logic           reset_n,
  package_assembler_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RX   = 2'd1,
    ST_CHK  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  byte_cnt_q, byte_cnt_d;
  logic [15:0] idle_cnt_q, idle_cnt_d;
  logic [63:0] shadow_q, shadow_d;
  logic [6:0]  shchild_q, shchild_d;
  logic [7:0]  csum_q, csum_d;
  logic [6:0]  child_q, child_d;
  logic [31:0] lat_q, lat_d;
  logic [31:0] lon_q, lon_d;
  logic        pv_q, pv_d;
  logic        fe_q, fe_d;
  logic        timeout_hit;

  // An idle cycle now would bring the stall counter to TIMEOUT.
  assign timeout_hit = ((idle_cnt_q + 16'd1) == TIMEOUT);

  // Next-state and datapath: frame parsing, commit, checksum and timeout.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    idle_cnt_d = idle_cnt_q;
    shadow_d   = shadow_q;
    shchild_d  = shchild_q;
    csum_d     = csum_q;
    child_d    = child_q;
    lat_d      = lat_q;
    lon_d      = lon_q;
    pv_d       = 1'b0;
    fe_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Only a byte with bit7 set starts a frame; fill bytes are ignored.
        if (bus.data_valid && bus.data_in[7]) begin
          shchild_d  = bus.data_in[6:0];
          byte_cnt_d = 4'd1;
          idle_cnt_d = 16'd0;
          csum_d     = bus.data_in;
          shadow_d   = 64'd0;
          state_d    = ST_RX;
        end
      end
      ST_RX: begin
        if (bus.data_valid) begin
          // Payload bytes are raw data: bit7 is not interpreted here.
          shadow_d   = {shadow_q[55:0], bus.data_in};
          csum_d     = csum_q ^ bus.data_in;
          idle_cnt_d = 16'd0;
          byte_cnt_d = byte_cnt_q + 4'd1;
          if (byte_cnt_q == 4'd8) begin
`ifdef CHECKSUM_EN
            state_d = ST_CHK;
`else
            child_d = shchild_q;
            lat_d   = shadow_d[63:32];
            lon_d   = shadow_d[31:0];
            pv_d    = 1'b1;
            state_d = ST_IDLE;
`endif
          end
        end else if (timeout_hit) begin
          fe_d       = 1'b1;
          idle_cnt_d = 16'd0;
          state_d    = ST_IDLE;
        end else begin
          idle_cnt_d = idle_cnt_q + 16'd1;
        end
      end
`ifdef CHECKSUM_EN
      ST_CHK: begin
        if (bus.data_valid) begin
          idle_cnt_d = 16'd0;
          state_d    = ST_IDLE;
          if (bus.data_in == csum_q) begin
            child_d = shchild_q;
            lat_d   = shadow_q[63:32];
            lon_d   = shadow_q[31:0];
            pv_d    = 1'b1;
          end else begin
            fe_d = 1'b1;
          end
        end else if (timeout_hit) begin
          fe_d       = 1'b1;
          idle_cnt_d = 16'd0;
          state_d    = ST_IDLE;
        end else begin
          idle_cnt_d = idle_cnt_q + 16'd1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset discards any partial frame silently.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      byte_cnt_q <= 4'd0;
      idle_cnt_q <= 16'd0;
      shadow_q   <= 64'd0;
      shchild_q  <= 7'd0;
      csum_q     <= 8'd0;
      child_q    <= 7'd0;
      lat_q      <= 32'd0;
      lon_q      <= 32'd0;
      pv_q       <= 1'b0;
      fe_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      shadow_q   <= shadow_d;
      shchild_q  <= shchild_d;
      csum_q     <= csum_d;
      child_q    <= child_d;
      lat_q      <= lat_d;
      lon_q      <= lon_d;
      pv_q       <= pv_d;
      fe_q       <= fe_d;
    end
  end

  assign bus.child        = child_q;
  assign bus.latitude     = lat_q;
  assign bus.longitude    = lon_q;
  assign bus.packet_valid = pv_q;
  assign bus.frame_error  = fe_q;
  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.state_dbg    = state_q;

endmodule

// File: tb/tb_package_assembler.sv
// Bench for package_assembler: directed steps from the test plan followed by
// randomized frames, checked against a frame-level reference model.
module tb_package_assembler;

  localparam logic [15:0] TIMEOUT = 16'd8;
  localparam int TOUT = 8;
`ifdef CHECKSUM_EN
  localparam int NB = 10;
`else
  localparam int NB = 9;
`endif

  logic clock;
  logic reset_n;
  int   n_pass;
  int   n_total;

  package_assembler_if bus_if();

  package_assembler #(.TIMEOUT(TIMEOUT)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  logic [7:0]  frm [0:9];
  logic [70:0] last_good;
  logic [70:0] exp_q [$];

  function automatic logic [7:0] model_xsum();
    logic [7:0] x;
    x = 8'd0;
    for (int i = 0; i < 9; i++) x = x ^ frm[i];
    return x;
  endfunction

  // Record a good frame decodes to, from the byte list.
  function automatic logic [70:0] model_rec();
    logic [31:0] la;
    logic [31:0] lo;
    logic [6:0]  ch;
    la = 32'd0;
    lo = 32'd0;
    for (int i = 1; i <= 4; i++) la = la * 256 + 32'(frm[i]);
    for (int i = 5; i <= 8; i++) lo = lo * 256 + 32'(frm[i]);
    ch = 7'(frm[0] % 128);
    return {ch, la, lo};
  endfunction

  task automatic load(input logic [6:0] ch, input logic [31:0] la, input logic [31:0] lo);
    frm[0] = {1'b1, ch};
    for (int i = 0; i < 4; i++) begin
      frm[1 + i] = 8'(la >> (8 * (3 - i)));
      frm[5 + i] = 8'(lo >> (8 * (3 - i)));
    end
    frm[9] = model_xsum();
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [70:0] obs_rec();
    return {bus_if.child, bus_if.latitude, bus_if.longitude};
  endfunction

  // Scoreboard: every packet_valid pulse must match the oldest expected record.
  always @(negedge clock) begin
    if (reset_n && (bus_if.packet_valid || bus_if.frame_error)) begin
      check("pulse_exclusive", {71'd0, bus_if.packet_valid & bus_if.frame_error}, 72'd0);
      if (bus_if.packet_valid) begin
        if (exp_q.size() == 0) check("sb_unexpected_pv", 72'd1, 72'd0);
        else check("sb_record", {1'b0, obs_rec()}, {1'b0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- drivers ----------------
  // Inputs change at a falling edge; returns at the next falling edge so the
  // caller observes the effect of the rising edge in between.
  task automatic step(input logic v, input logic [7:0] b);
    bus_if.data_valid = v;
    bus_if.data_in    = b;
    @(negedge clock);
    bus_if.data_valid = 1'b0;
  endtask

  // Sends the loaded frame with random inter-byte gaps in [gmin,gmax].
  task automatic send_frame(input int gmin, input int gmax, input bit good);
    for (int i = 0; i < NB; i++) begin
      step(1'b1, frm[i]);
      if (i == 0) check("busy_after_header", {71'd0, bus_if.busy}, 72'd1);
      if (i < NB - 1) begin
        check("no_early_pv", {71'd0, bus_if.packet_valid}, 72'd0);
        repeat ($urandom_range(gmax, gmin)) step(1'b0, 8'h00);
      end
    end
    if (good) begin
      last_good = model_rec();
      check("pv_pulse", {70'd0, bus_if.packet_valid, bus_if.frame_error}, 72'h2);
      check("record", {1'b0, obs_rec()}, {1'b0, last_good});
    end else begin
      check("fe_bad_csum", {70'd0, bus_if.packet_valid, bus_if.frame_error}, 72'h1);
      check("record_held", {1'b0, obs_rec()}, {1'b0, last_good});
    end
    check("busy_after_frame", {71'd0, bus_if.busy}, 72'd0);
  endtask

  // Queue the expectation, then send; the scoreboard checks the pulse.
  task automatic send_good(input int gmin, input int gmax);
    exp_q.push_back(model_rec());
    send_frame(gmin, gmax, 1'b1);
  endtask

  // Sends the first k bytes, then stalls until the timeout fires.
  task automatic send_trunc(input int k);
    for (int i = 0; i < k; i++) step(1'b1, frm[i]);
    repeat (TOUT - 1) step(1'b0, 8'h00);
    check("no_early_fe", {70'd0, bus_if.frame_error, bus_if.busy}, 72'h1);
    step(1'b0, 8'h00);
    check("fe_timeout", {70'd0, bus_if.packet_valid, bus_if.frame_error}, 72'h1);
    check("busy_after_timeout", {71'd0, bus_if.busy}, 72'd0);
    check("record_after_timeout", {1'b0, obs_rec()}, {1'b0, last_good});
    step(1'b0, 8'h00);
    check("fe_one_cycle", {71'd0, bus_if.frame_error}, 72'd0);
  endtask

  // ---------------- directed and random sequence ----------------
  initial begin
    n_pass  = 0;
    n_total = 0;
    last_good = '0;
    reset_n = 1'b0;
    bus_if.data_valid = 1'b0;
    bus_if.data_in    = 8'h00;
    repeat (3) @(negedge clock);
    check("reset_outputs", {1'b0, obs_rec()}, 72'd0);
    check("reset_flags", {69'd0, bus_if.packet_valid, bus_if.frame_error, bus_if.busy}, 72'd0);
    reset_n = 1'b1;
    step(1'b0, 8'h00);

    // Basic frame: FF 9D 03 BB 1F D8 CC 00 ED (+ 3C checksum).
    load(7'h7F, 32'h9D03BB1F, 32'hD8CC00ED);
    check("basic_csum_model", {64'd0, frm[9]}, 72'h3C);
    send_good(0, 0);
    check("basic_child", {65'd0, bus_if.child}, 72'h7F);
    check("basic_lat", {40'd0, bus_if.latitude}, 72'd2634267423);
    check("basic_lon", {40'd0, bus_if.longitude}, 72'd3637248237);
    step(1'b0, 8'h00);
    check("pv_one_cycle", {71'd0, bus_if.packet_valid}, 72'd0);

    // Idle filtering: 00 00 35 ignored.
    step(1'b1, 8'h00);
    check("idle_00_a", {71'd0, bus_if.busy}, 72'd0);
    step(1'b1, 8'h00);
    check("idle_00_b", {71'd0, bus_if.busy}, 72'd0);
    step(1'b1, 8'h35);
    check("idle_35", {71'd0, bus_if.busy}, 72'd0);
    send_good(0, 0);

    // Timeout after three bytes, then a frame decodes.
    load(7'h12, 32'h01020304, 32'hA0B0C0D0);
    send_trunc(3);
    send_good(0, 0);

    // Byte arriving on the would-be timeout cycle wins.
    load(7'h33, 32'hCAFEF00D, 32'h8BADF00D);
    send_good(TOUT - 1, TOUT - 1);

`ifdef CHECKSUM_EN
    // Bad checksum: 3D instead of 3C, outputs unchanged.
    load(7'h7F, 32'h9D03BB1F, 32'hD8CC00ED);
    frm[9] = 8'h3D;
    send_frame(0, 0, 1'b0);
    step(1'b0, 8'h00);
    check("fe_csum_one_cycle", {71'd0, bus_if.frame_error}, 72'd0);
`endif

    // Gapped frame (5-cycle gaps) then back-to-back 81 00 00 00 01 00 00 00 02.
    load(7'h7F, 32'h9D03BB1F, 32'hD8CC00ED);
    send_good(5, 5);
    load(7'h01, 32'd1, 32'd2);
    send_good(0, 0);
    check("b2b_final", {1'b0, obs_rec()}, {1'b0, 7'h01, 32'd1, 32'd2});

    // Reset mid-frame: outputs clear at once, no pulses.
    load(7'h55, 32'h11223344, 32'h55667788);
    for (int i = 0; i < 4; i++) step(1'b1, frm[i]);
    #2 reset_n = 1'b0;
    #1;
    check("midreset_outputs", {1'b0, obs_rec()}, 72'd0);
    check("midreset_flags", {69'd0, bus_if.packet_valid, bus_if.frame_error, bus_if.busy}, 72'd0);
    last_good = '0;
    @(negedge clock);
    reset_n = 1'b1;
    step(1'b0, 8'h00);
    send_good(0, 0);

    // Randomized frames with junk, gaps and occasional stalls.
    for (int f = 0; f < 24; f++) begin
      repeat ($urandom_range(3, 0)) begin
        step(1'b1, 8'($urandom_range(127, 0)));
        check("rand_junk_idle", {71'd0, bus_if.busy}, 72'd0);
      end
      load(7'($urandom_range(127, 0)), $urandom, $urandom);
      if ($urandom_range(3, 0) == 0) send_trunc($urandom_range(NB - 1, 1));
      else send_good(0, $urandom_range(TOUT - 1, 0));
    end

    step(1'b0, 8'h00);
    check("sb_drained", {40'd0, 32'(exp_q.size())}, 72'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
